gbuf_stream_reader: RTL and testbench
=====================================

# gbuf_stream_reader

Streaming read engine on port B of the dual-port global buffer (32768 × 16-bit). It accepts a burst command (base address, length) and issues one buffer read per cycle. It absorbs the buffer's one-cycle read latency and presents the words in address order on a valid/ready stream toward the downstream compute datapath. Flow control is credit-based, so no word is lost or duplicated when the consumer stalls.

## Interface
- STRIDE_W, default 15: width of the optional stride input (only present with the configuration macro).
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  reset, asynchronous, active-high.
- start_i  input  1  burst command strobe; accepted only when busy_o=0.
- base_addr_i  input  15  first buffer word address, sampled with start_i.
- len_i  input  16  number of words, 0..32768, sampled with start_i.
- stride_i  input  STRIDE_W  address increment, sampled with start_i (only with GBUF_RD_STRIDE_EN).
- busy_o  output  1  burst in progress.
- done_o  output  1  one-cycle pulse at burst completion.
- gb_addr_o  output  15  registered address to buffer port B.
- gb_rdata_i  input  16  buffer port B read data, valid one cycle after the address was presented.
- data_o  output  16  stream data (FIFO head).
- valid_o  output  1  stream data valid.
- last_o  output  1  qualifies the final word of the burst (meaningful only with valid_o).
- ready_i  input  1  consumer ready; transfer when valid_o && ready_i.

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE:
  - start_i with len_i>0 latches base, len and stride; goes to RUN; busy_o=1.
  - start_i with len_i=0 issues no reads, pulses done_o in the next cycle and stays IDLE.
- RUN:
  - A read issues in cycle t when issue_cnt<len and (fifo_count + inflight − pop_t) < 2, where pop_t = valid_o && ready_i in cycle t and inflight ∈ {0,1}.
  - Each issue drives gb_addr_o to the current address, then advances the address by 1 (or by stride) modulo 2^15. The address wraps from 32767 to 0 silently.
  - The word returned one cycle later is written into a 2-entry FIFO. The credit rule guarantees the FIFO never overflows.
  - When issue_cnt reaches len, the block moves to DRAIN.
- DRAIN: waits until inflight=0 and the FIFO is empty; the final beat carries last_o=1. In the cycle after the final handshake: done_o=1, busy_o=0, state returns to IDLE.
- start_i while busy_o=1 is ignored; no queueing.
- Word counters are 16 bits wide so len=32768 is representable. beat_cnt counts handshakes; last_o = (beat_cnt == len−1).
- gb_addr_o holds its last value when no read issues. Port B is read-only, so a spurious address has no side effects.
- Reset, including assertion mid-burst: state=IDLE; FIFO, counters and inflight cleared; valid_o=0, last_o=0, busy_o=0, done_o=0, gb_addr_o=0, data_o=0. Any read in flight at reset is discarded.

## Timing
- Start to first valid_o: start_i is sampled at edge 0, gb_addr_o is presented at edge 1, rdata is captured at edge 2, and valid_o=1 after edge 2. This is 3 cycles from the start_i cycle.
- Throughput: 1 word/cycle sustained while ready_i=1.
- Stall: ready_i=0 stops issue within the same cycle via the credit rule. At most 2 words are buffered. valid_o and data_o stay stable while ready_i=0.
- Restart after ready_i rises: transfers continue back-to-back with no bubble.
- done_o rises exactly 1 cycle after the last handshake. busy_o falls in the same cycle that done_o rises.
- A new start_i is accepted in the cycle done_o is high (busy_o=0).

## Configuration
- GBUF_RD_STRIDE_EN defined:
  - stride_i exists and is latched at start.
  - Address step = stride_i mod 2^15; stride 0 re-reads the base word len times.
- GBUF_RD_STRIDE_EN undefined: no stride_i port; the address step is fixed at 1.

## Test plan
- Contiguous burst: preload gbuff[i]=i+0x100; base=10, len=8, ready_i=1 -> 8 back-to-back beats 0x10A..0x111, first valid_o 3 cycles after start, last_o on 0x111, done_o one cycle later.
- Backpressure: base=0, len=16, ready_i random 50% -> exactly 16 in-order beats, no duplicate or skip, data stable while stalled, FIFO never exceeds 2.
- Wrap and zero length: base=32766, len=4 -> addresses 32766, 32767, 0, 1 in order. len=0 -> no gb_addr_o change, done_o pulse 1 cycle after start.
- Reset mid-burst and ignored start: assert rst_i asynchronously mid-burst after 5 of 20 beats -> all outputs 0 immediately. A fresh burst base=0, len=3 then completes correctly. start_i while busy -> ignored.
- Stride (GBUF_RD_STRIDE_EN): base=4, len=4, stride=3 -> addresses 4, 7, 10, 13. Stride 0 -> same word 4 times.
- Full buffer: len=32768, ready_i=1 -> 32768 beats, last_o only on the final beat, done_o once.

Source files
------------

// File: rtl/gbuf_stream_reader.sv
// Burst read engine for global-buffer port B: one read per cycle, credit-limited 2-entry FIFO.
// Optional feature macro: GBUF_RD_STRIDE_EN adds a latched stride_i address step (default step 1).
module gbuf_stream_reader #(
    parameter int unsigned STRIDE_W = 15
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic [14:0]         base_addr_i,
    input  logic [15:0]         len_i,
`ifdef GBUF_RD_STRIDE_EN
    input  logic [STRIDE_W-1:0] stride_i,
`endif
    output logic                busy_o,
    output logic                done_o,
    output logic [14:0]         gb_addr_o,
    input  logic [15:0]         gb_rdata_i,
    output logic [15:0]         data_o,
    output logic                valid_o,
    output logic                last_o,
    input  logic                ready_i
);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e      state_q;
    logic [14:0] addr_q;
    logic [14:0] gb_addr_q;
    logic [15:0] len_q;
    logic [15:0] issue_cnt_q;
    logic [15:0] beat_cnt_q;
    logic        inflight_q;
    logic [15:0] fifo_q [2];
    logic        wr_ptr_q;
    logic        rd_ptr_q;
    logic [1:0]  count_q;
    logic        done_q;
    logic [14:0] step;

`ifdef GBUF_RD_STRIDE_EN
    logic [14:0] step_q;
    assign step = step_q;
`else
    assign step = 15'd1;
`endif

    logic       pop;
    logic [2:0] credit;
    logic       issue;
    logic       last_beat;

    // Occupancy the FIFO will have once this cycle's pop and in-flight word settle.
    always_comb begin
        pop       = (count_q != 2'd0) && ready_i;
        credit    = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
        issue     = (state_q == StRun) && (issue_cnt_q < len_q) && (credit < 3'd2);
        last_beat = pop && (beat_cnt_q == len_q - 16'd1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            gb_addr_q   <= '0;
            len_q       <= '0;
            issue_cnt_q <= '0;
            beat_cnt_q  <= '0;
            inflight_q  <= 1'b0;
            fifo_q[0]   <= '0;
            fifo_q[1]   <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= '0;
            done_q      <= 1'b0;
`ifdef GBUF_RD_STRIDE_EN
            step_q      <= 15'd1;
`endif
        end else begin
            done_q     <= 1'b0;
            inflight_q <= issue;
            if (issue) begin
                gb_addr_q   <= addr_q;
                addr_q      <= addr_q + step;
                issue_cnt_q <= issue_cnt_q + 16'd1;
            end
            // Read data lands exactly one cycle after its address was issued.
            if (inflight_q) begin
                fifo_q[wr_ptr_q] <= gb_rdata_i;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q   <= ~rd_ptr_q;
                beat_cnt_q <= beat_cnt_q + 16'd1;
            end
            count_q <= count_q + {1'b0, inflight_q} - {1'b0, pop};

            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        if (len_i != 16'd0) begin
                            addr_q      <= base_addr_i;
                            len_q       <= len_i;
                            issue_cnt_q <= '0;
                            beat_cnt_q  <= '0;
`ifdef GBUF_RD_STRIDE_EN
                            step_q      <= 15'(stride_i);
`endif
                            state_q     <= StRun;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                StRun: begin
                    if (issue && (issue_cnt_q + 16'd1 == len_q)) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (last_beat) begin
                        state_q <= StIdle;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy_o    = (state_q != StIdle);
    assign done_o    = done_q;
    assign gb_addr_o = gb_addr_q;
    assign data_o    = fifo_q[rd_ptr_q];
    assign valid_o   = (count_q != 2'd0);
    assign last_o    = valid_o && (beat_cnt_q == len_q - 16'd1);

endmodule

// File: tb/tb_gbuf_stream_reader.sv
// Bench for gbuf_stream_reader: transaction-level model of expected beats/busy/done plus
// directed literal checks. Stride cases compile only with GBUF_RD_STRIDE_EN.
module tb_gbuf_stream_reader;

    localparam int unsigned STRIDE_W = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [14:0] base = '0;
    logic [15:0] len = '0;
`ifdef GBUF_RD_STRIDE_EN
    logic [STRIDE_W-1:0] stride = 1;
`endif
    logic        ready = 1'b1;
    logic        busy, done, valid, last;
    logic [14:0] gb_addr;
    logic [15:0] gb_rdata, data;
    logic [15:0] mem [32768];

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [15:0] d;
        bit          l;
    } beat_t;
    beat_t exp_q[$];
    bit    m_busy = 0;
    bit    m_done = 0;

    gbuf_stream_reader #(.STRIDE_W(STRIDE_W)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .base_addr_i (base),
        .len_i       (len),
`ifdef GBUF_RD_STRIDE_EN
        .stride_i    (stride),
`endif
        .busy_o      (busy),
        .done_o      (done),
        .gb_addr_o   (gb_addr),
        .gb_rdata_i  (gb_rdata),
        .data_o      (data),
        .valid_o     (valid),
        .last_o      (last),
        .ready_i     (ready)
    );

    // Buffer model: the registered address selects the word seen on the next edge.
    assign gb_rdata = mem[gb_addr];

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Model: a burst is the list mem[(base + k*step) mod 2^15], k < len, last on the final one.
    always @(negedge clk) begin
        bit          nb;
        bit          nd;
        logic [14:0] a;
        logic [14:0] st;
        if (rst) begin
            exp_q.delete();
            m_busy = 0;
            m_done = 0;
        end else begin
            nb = m_busy;
            nd = 0;
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            if (valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 1, 0);
                end else begin
                    chk("data", data, exp_q[0].d);
                    chk("last", last, exp_q[0].l);
                    if (ready) begin
                        if (exp_q[0].l) begin
                            nb = 0;
                            nd = 1;
                        end
                        void'(exp_q.pop_front());
                    end
                end
            end
            if (start && !m_busy) begin
                if (len == 16'd0) begin
                    nd = 1;
                end else begin
                    nb = 1;
                    a  = base;
`ifdef GBUF_RD_STRIDE_EN
                    st = 15'(stride);
`else
                    st = 15'd1;
`endif
                    for (int k = 0; k < int'(len); k++) begin
                        exp_q.push_back('{d: mem[a], l: (k == int'(len) - 1)});
                        a = a + st;
                    end
                end
            end
            m_busy = nb;
            m_done = nd;
        end
    end

    task automatic start_burst(input logic [14:0] b, input logic [15:0] l, input int s);
        @(posedge clk);
        #1;
        start = 1'b1;
        base  = b;
        len   = l;
`ifdef GBUF_RD_STRIDE_EN
        stride = STRIDE_W'(s);
`else
        if (s != 1) $display("note: stride %0d ignored without stride support", s);
`endif
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input bit rnd, input int budget);
        int n = 0;
        bit seen = 0;
        while (!seen && n < budget) begin
            ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (done) seen = 1;
            @(posedge clk);
            #1;
            n++;
        end
        ready = 1'b1;
        chk("done_within_budget", seen, 1);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 32768; i++) mem[i] = 16'(i + 'h100);

        #2;
        chk("rst_valid", valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_addr", gb_addr, 0);
        chk("rst_data", data, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Contiguous burst with literal timing; restart in the done cycle.
        start_burst(15'd10, 16'd8, 1);
        for (int i = 0; i <= 10; i++) begin
            @(negedge clk);
            if (i == 0) chk("lit_busy_after_start", busy, 1);
            if (i < 2) chk("lit_valid_early", valid, 0);
            if (i >= 2 && i <= 9) begin
                chk("lit_valid", valid, 1);
                chk("lit_data", data, 'h10A + i - 2);
                chk("lit_last", last, (i == 9));
            end
            if (i == 10) begin
                chk("lit_done", done, 1);
                chk("lit_busy_end", busy, 0);
                chk("lit_valid_end", valid, 0);
            end
            if (i == 9) begin
                @(posedge clk);
                #1;
                start = 1'b1;
                base  = 15'd20;
                len   = 16'd2;
            end
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(0, 20);

        // Backpressure.
        start_burst(15'd0, 16'd16, 1);
        wait_done(1, 200);

        // Wrap, then zero length leaves the address untouched.
        start_burst(15'd32766, 16'd4, 1);
        wait_done(0, 20);
        chk("wrap_addr_hold", gb_addr, 1);
        start_burst(15'd5, 16'd0, 1);
        @(negedge clk);
        chk("zero_done", done, 1);
        chk("zero_busy", busy, 0);
        chk("zero_addr", gb_addr, 1);
        @(negedge clk);
        chk("zero_done_once", done, 0);

        // Start while busy is ignored.
        start_burst(15'd100, 16'd6, 1);
        @(posedge clk);
        #1;
        start = 1'b1;
        base  = 15'd200;
        len   = 16'd2;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(1, 100);

        // Asynchronous reset after 5 of 20 beats.
        start_burst(15'd0, 16'd20, 1);
        n = 0;
        for (int c = 0; c < 50 && n < 5; c++) begin
            @(negedge clk);
            if (valid && ready) n++;
        end
        chk("beats_before_reset", n, 5);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", valid, 0);
        chk("mid_rst_last", last, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_addr", gb_addr, 0);
        chk("mid_rst_data", data, 0);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        start_burst(15'd0, 16'd3, 1);
        wait_done(0, 20);

`ifdef GBUF_RD_STRIDE_EN
        start_burst(15'd4, 16'd4, 3);
        wait_done(0, 20);
        chk("stride_last_addr", gb_addr, 13);
        start_burst(15'd4, 16'd4, 0);
        wait_done(1, 60);
        chk("stride0_addr", gb_addr, 4);
`endif

        // Whole buffer.
        start_burst(15'd0, 16'h8000, 1);
        wait_done(0, 33000);
        chk("full_last_addr", gb_addr, 32767);

        @(negedge clk);
        chk("model_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
